// File: rtl/regfile_wb_pkg.sv
// ============================================================================
// Module      : regfile_wb_pkg
// Description : Shared defaults and the write-back entry type for regfile_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

    localparam int REG_COUNT_DEF  = 32;
    localparam int REG_W_DEF      = 32;
    localparam int REG_IDX_W_DEF  = $clog2(REG_COUNT_DEF);
    localparam int FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic [REG_IDX_W_DEF-1:0] idx;
        logic [REG_W_DEF-1:0]     data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_fifo.sv
// ============================================================================
// Module      : regfile_wb_fifo
// Description : Circular write-back buffer with occupancy counter (power-of-two depth).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o     = (count_q == c_CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign w_do_push  = push_i && !full_o;
    assign w_do_pop   = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - c_CNT_W'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
// Module      : regfile_writeback
// Description : ALU/load result arbitration, write-back buffer, register-file
//               write port and RAW pending scoreboard.
//               Optional macro REGFILE_WB_BYPASS_EN enables the bypass port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int REG_COUNT  = REG_COUNT_DEF,
    parameter int REG_W      = REG_W_DEF,
    parameter int REG_IDX_W  = $clog2(REG_COUNT),
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_reg,
    input  logic [REG_W-1:0]     alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_IDX_W-1:0] mem_reg,
    input  logic [REG_W-1:0]     mem_data,
    input  logic                 iss_en,
    input  logic [REG_IDX_W-1:0] iss_reg,
    input  logic [REG_IDX_W-1:0] chk_reg_a,
    input  logic [REG_IDX_W-1:0] chk_reg_b,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] wr_reg,
    output logic [REG_W-1:0]     wr_data,
    output logic                 byp_valid,
    output logic [REG_IDX_W-1:0] byp_reg,
    output logic [REG_W-1:0]     byp_data
);

    localparam int c_ENTRY_W = REG_IDX_W + REG_W;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_push;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_wr_fire;
    logic                 w_fwd_a;
    logic                 w_fwd_b;

    logic                 wr_en_q;
    logic [REG_IDX_W-1:0] wr_reg_q;
    logic [REG_W-1:0]     wr_data_q;
    logic [REG_COUNT-1:0] pending_q;
    logic [REG_COUNT-1:0] pending_d;

    // Load results win arbitration; readiness never looks at the pop side.
    assign mem_ready   = !areset && !w_full;
    assign alu_ready   = !areset && !w_full && !mem_valid;
    assign w_push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign w_push_data = mem_valid ? {mem_reg, mem_data} : {alu_reg, alu_data};

    regfile_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .areset      (areset),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (!w_empty),
        .pop_data_o  (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    a_fifo_flags : assert property (@(posedge clk) disable iff (areset)
        (w_full == (w_count == c_CNT_W'(FIFO_DEPTH))) && (w_empty == (w_count == '0)));

    assign w_wr_fire = !w_empty && (w_head[REG_W +: REG_IDX_W] != '0);

    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d[wr_reg_q] = 1'b0;
        end
        if (iss_en && (iss_reg != '0)) begin
            pending_d[iss_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q <= w_wr_fire;
            if (w_wr_fire) begin
                wr_reg_q  <= w_head[REG_W +: REG_IDX_W];
                wr_data_q <= w_head[REG_W-1:0];
            end
            pending_q <= pending_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_valid = wr_en_q;
    assign byp_reg   = wr_reg_q;
    assign byp_data  = wr_data_q;
    assign w_fwd_a   = wr_en_q && (wr_reg_q == chk_reg_a);
    assign w_fwd_b   = wr_en_q && (wr_reg_q == chk_reg_b);
`else
    assign byp_valid = 1'b0;
    assign byp_reg   = '0;
    assign byp_data  = '0;
    assign w_fwd_a   = 1'b0;
    assign w_fwd_b   = 1'b0;
`endif

    assign busy_a = pending_q[chk_reg_a] && !w_fwd_a;
    assign busy_b = pending_q[chk_reg_b] && !w_fwd_b;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Randomised and directed bench for regfile_writeback against a
//               queue-based transaction model (honours REGFILE_WB_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;
    import regfile_wb_pkg::*;

    localparam int DEPTH = 4;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_reg = '0;
    logic [31:0] mem_data = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_reg = '0;
    logic [4:0]  chk_reg_a = '0;
    logic [4:0]  chk_reg_b = '0;
    logic        alu_ready, mem_ready, busy_a, busy_b, wr_en, byp_valid;
    logic [4:0]  wr_reg, byp_reg;
    logic [31:0] wr_data, byp_data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback dut (
        .clk       (clk),
        .areset    (areset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .iss_en    (iss_en),
        .iss_reg   (iss_reg),
        .chk_reg_a (chk_reg_a),
        .chk_reg_b (chk_reg_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .byp_valid (byp_valid),
        .byp_reg   (byp_reg),
        .byp_data  (byp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a queue of accepted results, the last architectural
    // write, and a pending bit per register.
    wb_entry_t   mq[$];
    bit          m_en   = 1'b0;
    logic [4:0]  m_reg  = '0;
    logic [31:0] m_data = '0;
    bit [31:0]   m_pend = '0;

    always @(posedge clk or posedge areset) begin : model
        bit         old_en;
        logic [4:0] old_reg;
        bit         room;
        wb_entry_t  e;
        if (areset) begin
            mq.delete();
            m_en   = 1'b0;
            m_reg  = '0;
            m_data = '0;
            m_pend = '0;
        end else begin
            old_en  = m_en;
            old_reg = m_reg;
            room    = (mq.size() < DEPTH);
            m_en    = 1'b0;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.idx != 0) begin
                    m_en   = 1'b1;
                    m_reg  = e.idx;
                    m_data = e.data;
                end
            end
            if (room && mem_valid) begin
                e.idx = mem_reg; e.data = mem_data; mq.push_back(e);
            end else if (room && alu_valid) begin
                e.idx = alu_reg; e.data = alu_data; mq.push_back(e);
            end
            if (old_en) m_pend[old_reg] = 1'b0;
            if (iss_en && iss_reg != 0) m_pend[iss_reg] = 1'b1;
            m_pend[0] = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        bit room;
        room = !areset && (mq.size() < DEPTH);
        check("mem_ready", mem_ready, room);
        check("alu_ready", alu_ready, room && !mem_valid);
        check("wr_en",     wr_en,     m_en);
        check("wr_reg",    wr_reg,    m_reg);
        check("wr_data",   wr_data,   m_data);
        check("busy_a",    busy_a,    m_pend[chk_reg_a] && !(c_BYP && m_en && m_reg == chk_reg_a));
        check("busy_b",    busy_b,    m_pend[chk_reg_b] && !(c_BYP && m_en && m_reg == chk_reg_b));
        check("byp_valid", byp_valid, c_BYP ? m_en : 1'b0);
        check("byp_reg",   byp_reg,   c_BYP ? m_reg : 5'd0);
        check("byp_data",  byp_data,  c_BYP ? m_data : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check("rst wr_en", wr_en, 1'b0);
        check("rst mem_ready", mem_ready, 1'b0);
        areset = 1'b0;

        // Single ALU write to r5 with a prior issue.
        tick();
        iss_en = 1'b1; iss_reg = 5'd5; chk_reg_a = 5'd5;
        tick();
        iss_en = 1'b0;
        check("r5 pending", busy_a, 1'b1);
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        check("r5 no early write", wr_en, 1'b0);
        tick();
        check("r5 wr_en", wr_en, 1'b1);
        check("r5 wr_reg", wr_reg, 5'd5);
        check("r5 wr_data", wr_data, 32'hDEADBEEF);
        check("r5 busy in write cycle", busy_a, c_BYP ? 1'b0 : 1'b1);
        tick();
        check("r5 wr_en drop", wr_en, 1'b0);
        check("r5 busy cleared", busy_a, 1'b0);

        // Simultaneous offers: load wins.
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'd2;
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'd1;
        #1;
        check("arb mem_ready", mem_ready, 1'b1);
        check("arb alu_ready", alu_ready, 1'b0);
        tick();
        mem_valid = 1'b0;
        #1;
        check("arb alu_ready after", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        check("arb first reg", wr_reg, 5'd2);
        check("arb first data", wr_data, 32'd2);
        tick();
        check("arb second reg", wr_reg, 5'd1);
        check("arb second data", wr_data, 32'd1);

        // Eight back-to-back pushes wrap the pointers twice.
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1'b1; alu_reg = 5'(8 + i); alu_data = $urandom;
            tick();
        end
        alu_valid = 1'b0;
        repeat (3) tick();

        // Destination r0 is consumed silently.
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h55; chk_reg_a = 5'd0;
        tick();
        mem_valid = 1'b0;
        repeat (2) begin
            tick();
            check("r0 no write", wr_en, 1'b0);
        end
        check("r0 hold reg", wr_reg, 5'd15);
        check("r0 not busy", busy_a, 1'b0);

        // Same-cycle set and clear on r7: set wins.
        chk_reg_a = 5'd7; iss_en = 1'b1; iss_reg = 5'd7;
        tick();
        iss_en = 1'b0;
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        tick();
        check("r7 wr_en", wr_en, 1'b1);
        check("r7 busy in write cycle", busy_a, c_BYP ? 1'b0 : 1'b1);
        check("r7 byp_data", byp_data, c_BYP ? 32'h77 : 32'h0);
        iss_en = 1'b1; iss_reg = 5'd7;
        tick();
        iss_en = 1'b0;
        check("r7 set wins", busy_a, 1'b1);
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h78;
        tick();
        alu_valid = 1'b0;
        repeat (2) tick();
        check("r7 finally clear", busy_a, 1'b0);

        // Reset while a write is in flight and an entry is buffered.
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
        tick();
        alu_reg = 5'd4; alu_data = 32'h44;
        tick();
        check("pre-reset wr_en", wr_en, 1'b1);
        #1;
        areset = 1'b1;
        #1;
        check("async rst wr_en", wr_en, 1'b0);
        check("async rst wr_reg", wr_reg, 5'd0);
        check("async rst wr_data", wr_data, 32'd0);
        check("async rst alu_ready", alu_ready, 1'b0);
        alu_valid = 1'b0;
        tick();
        areset = 1'b0;
        repeat (3) begin
            tick();
            check("no write after reset", wr_en, 1'b0);
        end

        // Randomised traffic over a small register window.
        for (int c = 0; c < 3000; c++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_reg   = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 99) < 35);
            mem_reg   = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            iss_en    = ($urandom_range(0, 99) < 40);
            iss_reg   = 5'($urandom_range(0, 7));
            chk_reg_a = 5'($urandom_range(0, 7));
            chk_reg_b = 5'($urandom_range(0, 7));
            areset    = ($urandom_range(0, 299) == 0);
            tick();
        end
        areset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; iss_en = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
